// File: rtl/mem_writer.sv
// mem_writer: streams valid/ready words into mem at consecutive word addresses from a base.
// Define MEM_WRITER_VERIFY_EN to read back every word and flag mismatches on error.
module mem_writer #(
  parameter int unsigned STRIDE = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [31:0]     base,
  input  logic [CNTW-1:0] count,
  input  logic [31:0]     dataIn,
  input  logic            dataValid,
  output logic            dataReady,
  output logic [31:0]     address,
  output logic [31:0]     memIn,
  output logic            memRead,
  output logic            memWrite,
  input  logic [31:0]     memOut,
  output logic            busy,
  output logic            done,
  output logic [CNTW-1:0] written,
  output logic            error,
  output logic [2:0]      dbg_state
);

  // Handshake: a word moves on a rising edge where dataValid and dataReady are both 1.
  // dataReady is registered and only high in ACCEPT; dataValid may rise at any time.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_WRITE  = 3'd2,
    S_CHECK  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] STEP = 32'(STRIDE);

  state_t          state_q, state_d;
  logic [31:0]     address_q, address_d;
  logic [31:0]     mem_in_q, mem_in_d;
  logic [CNTW-1:0] remaining_q, remaining_d;
  logic [CNTW-1:0] written_q, written_d;
  logic            ready_q, ready_d;
  logic            mem_read_q, mem_read_d;
  logic            mem_write_q, mem_write_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            error_q, error_d;
  logic            step_end, step_last;

`ifndef MEM_WRITER_VERIFY_EN
  logic mem_out_unused;
  assign mem_out_unused = ^memOut;
`endif

  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    mem_in_d    = mem_in_q;
    remaining_d = remaining_q;
    written_d   = written_q;
    ready_d     = ready_q;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    error_d     = error_q;
    step_end    = 1'b0;
    step_last   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count != '0) begin
            address_d   = {base[31:2], 2'b00};
            remaining_d = count;
            written_d   = '0;
            error_d     = 1'b0;
            busy_d      = 1'b1;
            ready_d     = 1'b1;
            state_d     = S_ACCEPT;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_ACCEPT: begin
        if (dataValid && ready_q) begin
          mem_in_d    = dataIn;
          mem_write_d = 1'b1;
          ready_d     = 1'b0;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        written_d   = written_q + CNTW'(1);
        remaining_d = remaining_q - CNTW'(1);
`ifdef MEM_WRITER_VERIFY_EN
        mem_read_d  = 1'b1;
        state_d     = S_CHECK;
`else
        step_end    = 1'b1;
        step_last   = (remaining_q == CNTW'(1));
`endif
      end
`ifdef MEM_WRITER_VERIFY_EN
      S_CHECK: begin
        // remaining was already decremented in WRITE, so zero means this was the last word
        if (memOut != mem_in_q) error_d = 1'b1;
        step_end  = 1'b1;
        step_last = (remaining_q == '0);
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (step_end) begin
      if (step_last) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        address_d = address_q + STEP;
        ready_d   = 1'b1;
        state_d   = S_ACCEPT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      address_q   <= '0;
      mem_in_q    <= '0;
      remaining_q <= '0;
      written_q   <= '0;
      ready_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      mem_in_q    <= mem_in_d;
      remaining_q <= remaining_d;
      written_q   <= written_d;
      ready_q     <= ready_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign dataReady = ready_q;
  assign address   = address_q;
  assign memIn     = mem_in_q;
  assign memRead   = mem_read_q;
  assign memWrite  = mem_write_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign written   = written_q;
  assign error     = error_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_writer.sv
// Bench for mem_writer: per-cycle outputs compared against a timeline computed from handshake arithmetic.
// Honours MEM_WRITER_VERIFY_EN to expect the read-back cadence and error flag.
`timescale 1ns/1ps
module tb_mem_writer;
  localparam int CNTW   = 16;
  localparam int STRIDE = 4;
  localparam int MAXW   = 16;
  localparam int MAXC   = 256;
`ifdef MEM_WRITER_VERIFY_EN
  localparam int P      = 3;
  localparam bit VERIFY = 1'b1;
`else
  localparam int P      = 2;
  localparam bit VERIFY = 1'b0;
`endif

  logic            clk, reset, start, data_valid, data_ready;
  logic [31:0]     base, data_in, address, mem_in, mem_out;
  logic [CNTW-1:0] count, written;
  logic            mem_read, mem_write, busy, done, error;
  logic [2:0]      dbg_state;

  mem_writer #(.STRIDE(STRIDE), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .dataIn(data_in), .dataValid(data_valid), .dataReady(data_ready),
    .address(address), .memIn(mem_in), .memRead(mem_read), .memWrite(mem_write),
    .memOut(mem_out), .busy(busy), .done(done), .written(written), .error(error),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, optional bit-0 fault at 0x84
  logic [31:0] mem_arr [0:255];
  logic        fault_en;
  always @(posedge clk) if (mem_write) mem_arr[address[9:2]] <= mem_in;
  assign mem_out = mem_arr[address[9:2]] ^ ((fault_en && address == 32'h84) ? 32'h1 : 32'h0);

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic note_fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out", name);
  endtask

  // reference timeline
  int              stall_a [MAXW];
  logic [31:0]     word_a  [MAXW];
  int              acc_a   [MAXW];
  logic            exp_rdy [MAXC], exp_wr [MAXC], exp_rd [MAXC];
  logic            exp_busy[MAXC], exp_done[MAXC], exp_err[MAXC];
  logic [31:0]     exp_addr[MAXC], exp_min[MAXC];
  logic [CNTW-1:0] exp_wrt [MAXC];
  int              exp_len, cyc, done_cyc, wr_cnt;
  bit              chk_active;
  logic [31:0]     wr_addr_q[$];
  logic [31:0]     exp_q[$];
  logic [31:0]     prev_addr, prev_min;
  logic [CNTW-1:0] prev_wrt;
  logic            prev_err;

  // Word i is accepted at cycle max(valid-rise, ready-rise); ready returns P cycles after each accept.
  task automatic build_model(input logic [31:0] b, input int n);
    logic [31:0] ab;
    int d, rdy_from, prev_acc, fin, acc, wrt, r_i;
    logic rdy, wr, rd, er;
    ab = {b[31:2], 2'b00};
    rdy_from = 1;
    prev_acc = 0;
    for (int i = 0; i < n; i++) begin
      int v;
      v = prev_acc + 1 + stall_a[i];
      acc_a[i] = (v > rdy_from) ? v : rdy_from;
      rdy_from = acc_a[i] + P;
      prev_acc = acc_a[i];
    end
    d = (n == 0) ? 1 : acc_a[n-1] + P;
    exp_len = d + 1;
    for (int c = 1; c <= d + 1; c++) begin
      fin = 0; acc = 0; wrt = 0; r_i = 1;
      rdy = 1'b0; wr = 1'b0; rd = 1'b0;
      er = (n == 0) ? prev_err : 1'b0;
      for (int i = 0; i < n; i++) begin
        if (acc_a[i] + P <= c) fin++;
        if (acc_a[i] < c) acc++;
        if (acc_a[i] + 1 < c) wrt++;
        if (c >= r_i && c <= acc_a[i]) rdy = 1'b1;
        if (c == acc_a[i] + 1) wr = 1'b1;
        if (VERIFY && c == acc_a[i] + 2) rd = 1'b1;
        if (VERIFY && fault_en && (ab + 32'(STRIDE * i)) == 32'h84 && acc_a[i] + 2 < c) er = 1'b1;
        r_i = acc_a[i] + P;
      end
      exp_rdy[c]  = rdy;
      exp_wr[c]   = wr;
      exp_rd[c]   = rd;
      exp_err[c]  = er;
      exp_busy[c] = (n > 0) && (c < d);
      exp_done[c] = (c == d);
      exp_addr[c] = (n == 0) ? prev_addr : ab + 32'(STRIDE * ((fin > n - 1) ? n - 1 : fin));
      exp_min[c]  = (acc > 0) ? word_a[acc-1] : prev_min;
      exp_wrt[c]  = (n == 0) ? prev_wrt : CNTW'(wrt);
    end
    prev_addr = exp_addr[d];
    prev_min  = exp_min[d];
    prev_wrt  = exp_wrt[d];
    prev_err  = exp_err[d];
  endtask

  // compare process: every cycle of a transfer, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (chk_active) begin
        check($sformatf("c%0d dataReady", cyc), data_ready, exp_rdy[cyc]);
        check($sformatf("c%0d memWrite", cyc),  mem_write,  exp_wr[cyc]);
        check($sformatf("c%0d memRead", cyc),   mem_read,   exp_rd[cyc]);
        check($sformatf("c%0d busy", cyc),      busy,       exp_busy[cyc]);
        check($sformatf("c%0d done", cyc),      done,       exp_done[cyc]);
        check($sformatf("c%0d error", cyc),     error,      exp_err[cyc]);
        check($sformatf("c%0d address", cyc),   address,    exp_addr[cyc]);
        check($sformatf("c%0d memIn", cyc),     mem_in,     exp_min[cyc]);
        check($sformatf("c%0d written", cyc),   32'(written), 32'(exp_wrt[cyc]));
        if (done) done_cyc = cyc;
        if (mem_write) begin
          wr_cnt++;
          wr_addr_q.push_back(address);
        end
        cyc++;
        if (cyc > exp_len) chk_active = 1'b0;
      end
    end
  end

  // driver
  task automatic run_transfer(input logic [31:0] b, input int n, input bit stray);
    int g;
    build_model(b, n);
    base  = b;
    count = CNTW'(n);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    base  = $urandom;
    count = CNTW'($urandom_range(0, 5));
    cyc = 1; done_cyc = 0; wr_cnt = 0;
    wr_addr_q.delete();
    chk_active = 1'b1;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          bit rdy;
          int w;
          data_valid = 1'b0;
          repeat (stall_a[i]) begin @(posedge clk); #1; end
          data_valid = 1'b1;
          data_in    = word_a[i];
          w = 0;
          do begin
            rdy = data_ready;
            @(posedge clk); #1;
            w++;
          end while (!rdy && w < 64);
          if (!rdy) note_fail("handshake");
        end
        data_valid = 1'b0;
        data_in    = $urandom;
      end
      begin
        if (stray && n > 0) begin
          @(posedge clk); #1;
          base  = $urandom;
          count = CNTW'(7);
          start = 1'b1;
          @(posedge clk); #1;
          start = 1'b0;
        end
      end
    join
    g = 0;
    while (chk_active && g < MAXC) begin @(posedge clk); g++; end
    if (chk_active) begin
      note_fail("transfer_end");
      chk_active = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] idx;
    logic [31:0] a0, a1;
    reset = 1'b1; start = 1'b0; base = '0; count = '0;
    data_in = '0; data_valid = 1'b0; fault_en = 1'b0; chk_active = 1'b0; cyc = 0;
    prev_addr = '0; prev_min = '0; prev_wrt = '0; prev_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst dataReady", data_ready, 0);
    check("rst address", address, 0);
    check("rst memWrite", mem_write, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst written", 32'(written), 0);
    check("rst state", 32'(dbg_state), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // basic write of three words, valid held high
    word_a[0] = 32'hA; word_a[1] = 32'hB; word_a[2] = 32'hC;
    for (int i = 0; i < MAXW; i++) stall_a[i] = 0;
    run_transfer(32'h80, 3, 1'b0);
    check("basic done cycle", done_cyc, VERIFY ? 10 : 7);
    check("basic written", 32'(written), 3);
    check("basic write pulses", wr_cnt, 3);
    exp_q.push_back(32'hA); exp_q.push_back(32'hB); exp_q.push_back(32'hC);
    for (int i = 0; i < 3; i++) begin
      a0  = 32'h80 + 32'(4 * i);
      idx = a0[9:2];
      check($sformatf("sweep %h", a0), mem_arr[idx], exp_q.pop_front());
    end

    // stalls of five cycles before each word
    word_a[0] = 32'h1111_2222; word_a[1] = 32'h3333_4444;
    stall_a[0] = 5; stall_a[1] = 5;
    run_transfer(32'h80, 2, 1'b0);
    check("stall write pulses", wr_cnt, 2);
    check("stall written", 32'(written), 2);

    // zero count then ignored start mid-transfer
    run_transfer(32'h200, 0, 1'b0);
    check("zero done cycle", done_cyc, 1);
    check("zero write pulses", wr_cnt, 0);
    stall_a[0] = 0; stall_a[1] = 2; stall_a[2] = 0;
    word_a[0] = 32'h5; word_a[1] = 32'h6; word_a[2] = 32'h7;
    run_transfer(32'h300, 3, 1'b1);
    check("busy start written", 32'(written), 3);

    // wrap and alignment
    stall_a[0] = 0; stall_a[1] = 0;
    word_a[0] = 32'hDEAD_0001; word_a[1] = 32'hDEAD_0002;
    run_transfer(32'hFFFF_FFFE, 2, 1'b0);
    a0 = (wr_addr_q.size() > 0) ? wr_addr_q[0] : 32'h1;
    a1 = (wr_addr_q.size() > 1) ? wr_addr_q[1] : 32'h1;
    check("wrap addr0", a0, 32'hFFFF_FFFC);
    check("wrap addr1", a1, 32'h0000_0000);

    // reset during the write of word 2 of 4
    base = 32'h100; count = CNTW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; data_valid = 1'b1; data_in = 32'h55;
    repeat (3) begin @(posedge clk); #1; end
    check("pre-reset memWrite", mem_write, 1);
    check("pre-reset address", address, 32'h104);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; data_valid = 1'b0;
    check("mid-reset dataReady", data_ready, 0);
    check("mid-reset address", address, 0);
    check("mid-reset memIn", mem_in, 0);
    check("mid-reset memWrite", mem_write, 0);
    check("mid-reset memRead", mem_read, 0);
    check("mid-reset busy", busy, 0);
    check("mid-reset written", 32'(written), 0);
    check("mid-reset error", error, 0);
    check("mid-reset state", 32'(dbg_state), 0);
    prev_addr = '0; prev_min = '0; prev_wrt = '0; prev_err = 1'b0;
    word_a[0] = 32'h77; stall_a[0] = 1;
    run_transfer(32'h40, 1, 1'b0);
    check("post-reset written", 32'(written), 1);

`ifdef MEM_WRITER_VERIFY_EN
    fault_en = 1'b1;
    for (int i = 0; i < 3; i++) begin stall_a[i] = 0; word_a[i] = 32'h100 + 32'(i); end
    run_transfer(32'h80, 3, 1'b0);
    check("verify error latched", error, 1);
    fault_en = 1'b0;
    run_transfer(32'h80, 3, 1'b0);
    check("verify clean rerun", error, 0);
`endif

    // randomized transfers
    for (int t = 0; t < 30; t++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 8));
      for (int i = 0; i < MAXW; i++) begin
        stall_a[i] = $urandom_range(0, 3);
        word_a[i]  = $urandom;
      end
      run_transfer($urandom, n, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_writer.md
# mem_writer

Sequential write engine for the word-addressed `mem` block; it is the write-side counterpart to the existing read sweep. After a start pulse it accepts a stream of 32-bit words over a valid/ready handshake and writes them to `mem` at consecutive word addresses from a programmable base. It drives `mem`'s `address`, `memIn`, `memRead` and `memWrite` inputs directly and observes `memOut`. It reports progress, completion and, optionally, read-back mismatches.

## Interface
Parameters:
- STRIDE, 4: byte increment between consecutive word addresses.
- CNTW, 16: width of the word count and the progress counter.

Ports (one clock, `clk`; reset `reset` is synchronous and active-high):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- base  in  32  first byte address; bits [1:0] are forced to 0 on capture.
- count  in  CNTW  number of words to write; sampled with `start`.
- dataIn  in  32  write data.
- dataValid  in  1  `dataIn` is valid.
- dataReady  out  1  engine accepts `dataIn` this cycle.
- address  out  32  to `mem` address.
- memIn  out  32  to `mem` write data.
- memRead  out  1  to `mem` read enable.
- memWrite  out  1  to `mem` write enable.
- memOut  in  32  from `mem`; the read path is combinational.
- busy  out  1  a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- written  out  CNTW  words committed in the current or last transfer.
- error  out  1  sticky read-back mismatch (verify build only; otherwise tied to 0).

## Operation
- All outputs are registered. Every output resets to 0.
- States: IDLE, ACCEPT, WRITE, CHECK (verify build only), DONE.
- IDLE behaviour:
  - `busy`=0 and `dataReady`=0.
  - `start` with `count`≠0: capture `base`, set `remaining`=`count`, clear `written` and `error`, set `busy`=1, go to ACCEPT.
  - `start` with `count`=0: pulse `done` for one cycle and stay in IDLE.
- ACCEPT: `dataReady`=1. On `dataValid`&`dataReady`, capture `memIn`<=`dataIn`, set `memWrite`<=1, drop `dataReady`, go to WRITE.
- WRITE: `memWrite`=1 for exactly one cycle; `mem` commits at the edge that ends this cycle. `written` increments and `remaining` decrements at that edge. Next state:
  - verify build: CHECK.
  - otherwise, `remaining` was 1: DONE.
  - otherwise: `address`+=STRIDE, go to ACCEPT.
- CHECK: `memWrite`=0 and `memRead`=1. At the ending edge, compare `memOut` with `memIn`; a mismatch sets `error`. Then apply the same remaining/advance rule as WRITE. `memRead` is 0 in every other state.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE. `address`, `memIn` and `written` hold their values until the next start.
- Address arithmetic is modulo 2^32; 0xFFFFFFFC + 4 wraps to 0x00000000.
- `start` outside IDLE is ignored.
- `memRead` and `memWrite` are never 1 in the same cycle.

## Timing
- Latency from `start` to the first `dataReady`: 1 cycle.
- Throughput: 2 cycles per word (3 in the verify build), plus any cycles the source stalls `dataValid`.
- For N words with `dataValid` held high, `done` asserts 2N+1 cycles after the `start` edge (3N+1 in the verify build).
- A `dataValid` stall holds ACCEPT indefinitely; `address` is stable during the stall.
- `reset` asserted in any state: at that edge go to IDLE, and all outputs, including `memWrite`, are 0. A write in flight is abandoned; whether the word was committed depends on `mem` sampling at the same edge.

## Configuration
- MEM_WRITER_VERIFY_EN defined:
  - CHECK state is present.
  - every word is read back one cycle after its write.
  - `error` latches on mismatch until the next accepted `start` or `reset`.
- Not defined:
  - no CHECK state; `memRead` is constant 0.
  - `error` is constant 0.
  - 2-cycle cadence.

## Test plan
- Basic write: `base`=0x80, `count`=3, words 0x0000000A/0x0000000B/0x0000000C with valid held high -> writes at 0x80/0x84/0x88. A following read sweep of 0x80–0x88 returns the same words. `written`=3, `done` at cycle 7 (10 with verify).
- Stalls: `count`=2, `dataValid` low for 5 cycles before each word -> `address` holds 0x80 during the first stall. `memWrite` pulses exactly twice, each for one cycle.
- Zero count and busy start: `count`=0 -> `done` 1 cycle after `start`, no `memWrite`. A second `start` pulsed mid-transfer is ignored: `written` still equals the original `count`.
- Wrap and alignment: `base`=0xFFFFFFFE, `count`=2 -> writes at 0xFFFFFFFC, then 0x00000000.
- Reset mid-transfer: assert `reset` during WRITE of word 2 of 4 -> next cycle all outputs are 0 and the state is IDLE. A new `start` then proceeds normally.
- Verify (MEM_WRITER_VERIFY_EN): a memory model that flips bit 0 at address 0x84 -> `error`=1 after word 2 and stays 1 through `done`. A clean rerun -> `error`=0.
